// File: rtl/forwarding_pkg.sv
// -----------------------------------------------------------------------------
// forwarding_pkg
// Shared types and constants for the operand-forwarding / load-use hazard unit.
//   REG_ADDR_W : register index width
//   ZERO_REG   : hardwired-zero register (XZR), never forwarded
//   sel_t      : ALU operand mux select encoding
// -----------------------------------------------------------------------------
package forwarding_pkg;

   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

   localparam reg_idx_t ZERO_REG = reg_idx_t'(31);

   typedef enum logic [1:0] {
      SEL_REG   = 2'b00,
      SEL_EXMEM = 2'b01,
      SEL_MEMWB = 2'b10,
      SEL_IMM   = 2'b11
   } sel_t;

endpackage

// File: rtl/forwarding_unit_if.sv
// -----------------------------------------------------------------------------
// forwarding_unit_if
// EX-stage hazard bus between the pipeline datapath and the forwarding unit.
//   master : datapath side, drives EX-stage instruction info, receives selects
//   slave  : forwarding unit side
// Signals: advance, flush, ex_rn, ex_rm, ex_rd, ex_regwrite, ex_is_load,
//          ex_use_imm (to unit); sel_a, sel_b, stall (from unit).
// -----------------------------------------------------------------------------
interface forwarding_unit_if;
   import forwarding_pkg::*;

   logic       advance;
   logic       flush;
   reg_idx_t   ex_rn;
   reg_idx_t   ex_rm;
   reg_idx_t   ex_rd;
   logic       ex_regwrite;
   logic       ex_is_load;
   logic       ex_use_imm;
   logic [1:0] sel_a;
   logic [1:0] sel_b;
   logic       stall;

   modport master (
      output advance, flush, ex_rn, ex_rm, ex_rd, ex_regwrite, ex_is_load, ex_use_imm,
      input  sel_a, sel_b, stall
   );

   modport slave (
      input  advance, flush, ex_rn, ex_rm, ex_rd, ex_regwrite, ex_is_load, ex_use_imm,
      output sel_a, sel_b, stall
   );

endinterface

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Per-operand forwarding priority comparator.
//   i_src            : source register of the EX-stage operand
//   i_mem_rd/we/ld   : EX/MEM tracked destination, write enable, load flag
//   i_wb_rd/we       : MEM/WB tracked destination, write enable
//   o_sel            : SEL_EXMEM, else SEL_MEMWB, else SEL_REG
// -----------------------------------------------------------------------------
module fwd_select
   import forwarding_pkg::*;
(
   input  reg_idx_t i_src,
   input  reg_idx_t i_mem_rd,
   input  logic     i_mem_we,
   input  logic     i_mem_ld,
   input  reg_idx_t i_wb_rd,
   input  logic     i_wb_we,
   output sel_t     o_sel
);

   always_comb begin
      o_sel = SEL_REG;
      if (i_src != ZERO_REG) begin
         // A load in EX/MEM has no data yet; fall through to the older MEM/WB write.
         if (i_mem_we && !i_mem_ld && (i_mem_rd == i_src)) begin
            o_sel = SEL_EXMEM;
         end else if (i_wb_we && (i_wb_rd == i_src)) begin
            o_sel = SEL_MEMWB;
         end
      end
   end

endmodule

// File: rtl/forwarding_unit.sv
// -----------------------------------------------------------------------------
// forwarding_unit
// Operand-forwarding and load-use hazard unit for the 64-bit pipeline.
// Tracks destination registers through EX/MEM and MEM/WB and drives the two
// ALU operand mux selects (00 regfile, 01 EX/MEM, 10 MEM/WB, 11 immediate).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : forwarding_unit_if.slave (EX-stage info in, selects/stall out)
// Optional build macro FWD_PERF_COUNT_EN adds saturating counters:
//   fwd_count   : advancing cycles with any operand forwarded (01 or 10)
//   stall_count : advancing stall cycles
// -----------------------------------------------------------------------------
module forwarding_unit
   import forwarding_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   forwarding_unit_if.slave    bus
`ifdef FWD_PERF_COUNT_EN
   ,
   output logic [31:0]         fwd_count,
   output logic [31:0]         stall_count
`endif
);

   reg_idx_t r_mem_rd;
   logic     r_mem_we;
   logic     r_mem_ld;
   reg_idx_t r_wb_rd;
   logic     r_wb_we;

   sel_t     w_sel_a;
   sel_t     w_sel_b_fwd;
   logic     w_stall;

   fwd_select u_sel_a (
      .i_src    (bus.ex_rn),
      .i_mem_rd (r_mem_rd),
      .i_mem_we (r_mem_we),
      .i_mem_ld (r_mem_ld),
      .i_wb_rd  (r_wb_rd),
      .i_wb_we  (r_wb_we),
      .o_sel    (w_sel_a)
   );

   fwd_select u_sel_b (
      .i_src    (bus.ex_rm),
      .i_mem_rd (r_mem_rd),
      .i_mem_we (r_mem_we),
      .i_mem_ld (r_mem_ld),
      .i_wb_rd  (r_wb_rd),
      .i_wb_we  (r_wb_we),
      .o_sel    (w_sel_b_fwd)
   );

   // Operand B only creates a hazard when it actually comes from a register.
   assign w_stall = r_mem_ld && r_mem_we && (r_mem_rd != ZERO_REG) &&
                    ((r_mem_rd == bus.ex_rn) ||
                     ((r_mem_rd == bus.ex_rm) && !bus.ex_use_imm));

   assign bus.sel_a = w_sel_a;
   assign bus.sel_b = bus.ex_use_imm ? SEL_IMM : w_sel_b_fwd;
   assign bus.stall = w_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_rd <= '0;
         r_mem_we <= 1'b0;
         r_mem_ld <= 1'b0;
         r_wb_rd  <= '0;
         r_wb_we  <= 1'b0;
      end else if (bus.advance) begin
         if (w_stall) begin
            // Bubble into EX/MEM; clearing mem_ld ends the stall after one cycle.
            r_mem_rd <= '0;
            r_mem_we <= 1'b0;
            r_mem_ld <= 1'b0;
         end else begin
            r_mem_rd <= bus.ex_rd;
            r_mem_we <= bus.ex_regwrite && !bus.flush;
            r_mem_ld <= bus.ex_is_load && !bus.flush;
         end
         r_wb_rd <= r_mem_rd;
         r_wb_we <= r_mem_we;
      end
   end

`ifdef FWD_PERF_COUNT_EN
   logic w_fwd_any;

   assign w_fwd_any = (w_sel_a == SEL_EXMEM) || (w_sel_a == SEL_MEMWB) ||
                      (bus.sel_b == SEL_EXMEM) || (bus.sel_b == SEL_MEMWB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_count   <= '0;
         stall_count <= '0;
      end else if (bus.advance) begin
         if (w_fwd_any && (fwd_count != 32'hFFFF_FFFF)) begin
            fwd_count <= fwd_count + 32'd1;
         end
         if (w_stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
module tb_forwarding_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   forwarding_unit_if bus();

`ifdef FWD_PERF_COUNT_EN
   logic [31:0] fwd_count;
   logic [31:0] stall_count;
`endif

   forwarding_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus)
`ifdef FWD_PERF_COUNT_EN
      ,
      .fwd_count   (fwd_count),
      .stall_count (stall_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: list of instructions that have left EX, newest first.
   // Entry 0 is the one now in MEM, entry 1 the one now in WB.
   typedef struct {
      logic [4:0] rd;
      logic       we;
      logic       ld;
   } retired_t;

   retired_t hist[$];

   task automatic model_clear();
      retired_t z;
      z.rd = 5'd0; z.we = 1'b0; z.ld = 1'b0;
      hist = {};
      hist.push_back(z);
      hist.push_back(z);
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] src);
      if (src == 5'd31) return 2'b00;
      if (hist[0].we && !hist[0].ld && hist[0].rd == src) return 2'b01;
      if (hist[1].we && hist[1].rd == src) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [1:0] m_sel_b();
      if (bus.ex_use_imm) return 2'b11;
      return m_fwd(bus.ex_rm);
   endfunction

   function automatic logic m_stall();
      if (!(hist[0].ld && hist[0].we) || hist[0].rd == 5'd31) return 1'b0;
      return (hist[0].rd == bus.ex_rn) || (hist[0].rd == bus.ex_rm && !bus.ex_use_imm);
   endfunction

   task automatic set_ex(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic we, input logic ld, input logic imm,
                         input logic fl, input logic adv);
      bus.ex_rn = rn; bus.ex_rm = rm; bus.ex_rd = rd;
      bus.ex_regwrite = we; bus.ex_is_load = ld; bus.ex_use_imm = imm;
      bus.flush = fl; bus.advance = adv;
   endtask

   // One clock edge; the model retires the EX instruction if the pipe advances.
   task automatic tick();
      retired_t e;
      logic st;
      st = m_stall();
      e.rd = st ? 5'd0 : bus.ex_rd;
      e.we = st ? 1'b0 : (bus.ex_regwrite && !bus.flush);
      e.ld = st ? 1'b0 : (bus.ex_is_load && !bus.flush);
      @(posedge clk);
      if (bus.advance) begin
         hist.push_front(e);
         void'(hist.pop_back());
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      set_ex(5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.sel_a !== 2'b00 || bus.sel_b !== 2'b00 || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_sels: got sel_a=%b sel_b=%b stall=%b, expected 00 00 0",
                  bus.sel_a, bus.sel_b, bus.stall);
      end
      bus.ex_use_imm = 1'b1;
      #1;
      checks++;
      if (bus.sel_b !== 2'b11) begin
         errors++;
         $display("FAIL reset_imm: got sel_b=%b, expected 11", bus.sel_b);
      end
      bus.ex_use_imm = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.sel_a !== 2'b00 || bus.sel_b !== 2'b00 || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: got sel_a=%b sel_b=%b stall=%b, expected 00 00 0",
                  bus.sel_a, bus.sel_b, bus.stall);
      end
      tick();
   endtask

   task automatic test_forward_stages();
      set_ex(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_ex(5'd3, 5'd1, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.sel_a !== 2'b01) begin
         errors++;
         $display("FAIL exmem_fwd: got sel_a=%b, expected 01", bus.sel_a);
      end
      tick();
      set_ex(5'd3, 5'd1, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.sel_a !== 2'b10) begin
         errors++;
         $display("FAIL memwb_fwd: got sel_a=%b, expected 10", bus.sel_a);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      set_ex(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      set_ex(5'd0, 5'd5, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.sel_b !== 2'b01) begin
         errors++;
         $display("FAIL exmem_priority: got sel_b=%b, expected 01", bus.sel_b);
      end
      bus.ex_use_imm = 1'b1;
      #1;
      checks++;
      if (bus.sel_b !== 2'b11) begin
         errors++;
         $display("FAIL imm_override: got sel_b=%b, expected 11", bus.sel_b);
      end
      tick();
   endtask

   task automatic test_load_use();
      set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_ex(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      set_ex(5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1 || bus.sel_a !== 2'b00) begin
         errors++;
         $display("FAIL load_use_stall: got stall=%b sel_a=%b, expected 1 00",
                  bus.stall, bus.sel_a);
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0 || bus.sel_a !== 2'b10) begin
         errors++;
         $display("FAIL load_use_release: got stall=%b sel_a=%b, expected 0 10",
                  bus.stall, bus.sel_a);
      end
      tick();
      set_ex(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.sel_a !== 2'b01) begin
         errors++;
         $display("FAIL held_instr_tracked: got sel_a=%b, expected 01", bus.sel_a);
      end
      tick();
   endtask

   task automatic test_zero_and_flush();
      set_ex(5'd0, 5'd0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      set_ex(5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.sel_a !== 2'b00 || bus.sel_b !== 2'b00 || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL zero_reg: got sel_a=%b sel_b=%b stall=%b, expected 00 00 0",
                  bus.sel_a, bus.sel_b, bus.stall);
      end
      tick();
      set_ex(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      set_ex(5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.sel_a !== 2'b00 || bus.sel_b !== 2'b00) begin
         errors++;
         $display("FAIL flush_exmem: got sel_a=%b sel_b=%b, expected 00 00", bus.sel_a, bus.sel_b);
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.sel_a !== 2'b00) begin
         errors++;
         $display("FAIL flush_memwb: got sel_a=%b, expected 00", bus.sel_a);
      end
      tick();
   endtask

   task automatic test_advance_hold();
      set_ex(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_ex(5'd2, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.sel_a !== 2'b01) begin
            errors++;
            $display("FAIL advance_hold[%0d]: got sel_a=%b, expected 01", i, bus.sel_a);
         end
         tick();
      end
      bus.flush = 1'b0;
      bus.ex_is_load = 1'b0;
      bus.advance = 1'b1;
      tick();
   endtask

   task automatic test_async_reset();
      set_ex(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_ex(5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.sel_a !== 2'b01) begin
         errors++;
         $display("FAIL pre_reset_fwd: got sel_a=%b, expected 01", bus.sel_a);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.sel_a !== 2'b00 || bus.sel_b !== 2'b00) begin
         errors++;
         $display("FAIL async_reset: got sel_a=%b sel_b=%b, expected 00 00", bus.sel_a, bus.sel_b);
      end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic [4:0] pick [8];
      logic [1:0] exp_a, exp_b;
      logic       exp_st;
      pick[0] = 5'd1; pick[1] = 5'd2; pick[2] = 5'd3; pick[3] = 5'd4;
      pick[4] = 5'd5; pick[5] = 5'd6; pick[6] = 5'd31; pick[7] = 5'd0;
      for (int n = 0; n < 400; n++) begin
         set_ex(pick[$urandom_range(7)], pick[$urandom_range(7)], pick[$urandom_range(7)],
                1'($urandom_range(3) != 0), 1'($urandom_range(2) == 0),
                1'($urandom_range(3) == 0), 1'($urandom_range(9) == 0),
                1'($urandom_range(9) != 0));
         @(negedge clk);
         exp_a = m_fwd(bus.ex_rn);
         exp_b = m_sel_b();
         exp_st = m_stall();
         checks++;
         if (bus.sel_a !== exp_a || bus.sel_b !== exp_b || bus.stall !== exp_st) begin
            errors++;
            $display("FAIL random[%0d]: got sel_a=%b sel_b=%b stall=%b, expected %b %b %b",
                     n, bus.sel_a, bus.sel_b, bus.stall, exp_a, exp_b, exp_st);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_forward_stages();
      test_back_to_back();
      test_load_use();
      test_zero_and_flush();
      test_advance_hold();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Sequential operand-forwarding and load-use hazard unit for the 64-bit pipelined datapath.
- Tracks destination registers through the EX/MEM and MEM/WB stages.
- Drives the 2-bit select lines of the two 4-input 64-bit ALU operand multiplexers directly upstream of the ALU:
  - 00 register file
  - 01 EX/MEM result
  - 10 MEM/WB result
  - 11 immediate
- Raises a stall when a load result is not yet available.

Parameters:
- REG_ADDR_W, 5, register index width.
- ZERO_REG, 31, index of hardwired-zero register XZR; never forwarded.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- advance  input  1  pipeline enable; stage tracking shifts only when 1.
- flush  input  1  squash the instruction leaving EX (branch taken).
- ex_rn  input  5  EX-stage source register A.
- ex_rm  input  5  EX-stage source register B.
- ex_rd  input  5  EX-stage destination register.
- ex_regwrite  input  1  EX instruction writes ex_rd.
- ex_is_load  input  1  EX instruction is LDUR.
- ex_use_imm  input  1  operand B comes from immediate.
- sel_a  output  2  select for operand-A mux.
- sel_b  output  2  select for operand-B mux.
- stall  output  1  load-use hazard; hold PC, IF/ID and ID/EX.

Behaviour:
- Reset: rst_n=0 asynchronously clears all internal state:
  - mem_rd=0, mem_we=0, mem_ld=0.
  - wb_rd=0, wb_we=0.
  - Outputs therefore read sel_a=00, sel_b=00 (or 11 if ex_use_imm), stall=0.
  - Reset mid-pipeline discards all tracked writes; the first cycle after release never forwards.
- State update, rising clk with advance=1:
  - stall=0:
    - mem_rd<=ex_rd.
    - mem_we<=ex_regwrite & ~flush.
    - mem_ld<=ex_is_load & ~flush.
  - stall=1: EX/MEM receives a bubble (mem_we<=0, mem_ld<=0, mem_rd<=0).
  - Always: wb_rd<=mem_rd, wb_we<=mem_we.
- State update, advance=0: all state holds, regardless of flush or stall.
- Select logic (combinational from state plus EX inputs; zero latency, valid the same cycle):
  - Priority per operand:
    1. 01 if mem_we & ~mem_ld & mem_rd==src & src!=ZERO_REG.
    2. Else 10 if wb_we & wb_rd==src & src!=ZERO_REG.
    3. Else 00.
  - EX/MEM beats MEM/WB when both match the same register (most recent write wins).
  - sel_b=11 whenever ex_use_imm=1, overriding all forwarding.
- Stall logic:
  - stall=1 when mem_ld & mem_we & mem_rd!=ZERO_REG and either:
    - mem_rd==ex_rn, or
    - mem_rd==ex_rm with ex_use_imm=0.
  - While stall=1, sels still reflect the MEM/WB match; the datapath ignores them.
  - Stall lasts exactly one advancing cycle, because the bubble clears mem_ld.
- flush and stall in the same cycle: bubble results either way; flush has no further effect.
- Writes to ZERO_REG are tracked but never matched.

Optional Feature:
- Macro: FWD_PERF_COUNT_EN.
- When defined:
  - Adds outputs fwd_count[31:0] and stall_count[31:0].
  - fwd_count: saturating count of advancing cycles where sel_a or sel_b is 01 or 10.
  - stall_count: saturating count of advancing stall cycles.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined: ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Package forwarding_pkg:
  - SEL_REG=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10, SEL_IMM=2'b11.
  - ZERO_REG constant.
  - Typedef for the 5-bit register index.
- Sub-module fwd_select: per-operand priority comparator (inputs src, mem_rd, mem_we, mem_ld, wb_rd, wb_we; output 2-bit select). Instantiated twice.

Test Plan:
- Reset then ex_rn=3, ex_rm=4, no prior writes -> sel_a=00, sel_b=00, stall=0.
- ADD X3 (regwrite), next cycle ex_rn=3 -> sel_a=01. Following cycle, with an unrelated instruction between -> sel_a=10.
- Back-to-back writes to X5, then ex_rm=5 -> sel_b=01 (EX/MEM priority over MEM/WB). With ex_use_imm=1 -> sel_b=11.
- LDUR X7, next ex_rn=7 -> stall=1 for one cycle, then sel_a=10, stall=0.
- Write to X31, then ex_rn=31 -> sel_a=00. Flush on a write to X9, then ex_rn=9 -> sel_a=00.
- advance=0 for 3 cycles after a write to X2 -> sel stays 01 throughout.
- rst_n pulsed mid-sequence -> sels return to 00 asynchronously.
